// File: rtl/fp_normalize_round.sv
// Normalize/round/pack stage of the FP adder: left-normalizes one bit per cycle, rounds to nearest-even.
// Latency: 2 + shift count edges from accept to out_valid; Inf/NaN and exact cancellation go straight to DONE.
// Backpressure: one transaction in flight; in_ready only in IDLE, DONE holds result until out_ready.
module fp_normalize_round #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sign,
    input  logic [EXP_WIDTH-1:0]            in_exponent,
    input  logic                            in_carry,
    input  logic [MANT_WIDTH:0]             in_mantissa,
    input  logic                            in_guard,
    input  logic                            in_round,
    input  logic                            in_sticky,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0]   out_result,
    output logic                            out_overflow,
    output logic                            out_underflow,
    output logic                            busy
);

    localparam int WM      = MANT_WIDTH + 4;
    localparam int WE      = EXP_WIDTH + 1;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;
    localparam logic [WE-1:0] EXP_ONE = WE'(1);
    localparam logic [WE-1:0] EXP_SAT = WE'(EXP_MAX);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                         state;
    logic [WM-1:0]                  workMant;
    logic [WE-1:0]                  workExp;
    logic                           workSign;
    logic [EXP_WIDTH+MANT_WIDTH:0]  resultReg;
    logic                           overflowReg;
    logic                           underflowReg;
    logic                           validReg;

    logic [WM-1:0]                  captureMant;
    logic                           roundInc;
    logic [MANT_WIDTH+1:0]          roundSum;
    logic [MANT_WIDTH-1:0]          roundFrac;
    logic [WE-1:0]                  roundExp;

    assign captureMant = {in_mantissa, in_guard, in_round, in_sticky};

    // Round-to-nearest-even on the normalized mantissa; a carry out of the
    // increment renormalizes by one bit and bumps the exponent.
    always_comb begin
        roundInc  = workMant[2] & (workMant[1] | workMant[0] | workMant[3]);
        roundSum  = {1'b0, workMant[WM-1:3]} + {{(MANT_WIDTH+1){1'b0}}, roundInc};
        roundFrac = roundSum[MANT_WIDTH-1:0];
        roundExp  = workExp;
        if (roundSum[MANT_WIDTH+1]) begin
            roundFrac = roundSum[MANT_WIDTH:1];
            roundExp  = workExp + EXP_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            workMant     <= '0;
            workExp      <= '0;
            workSign     <= 1'b0;
            resultReg    <= '0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
            validReg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        workSign     <= in_sign;
                        workMant     <= captureMant;
                        workExp      <= {1'b0, in_exponent};
                        overflowReg  <= 1'b0;
                        underflowReg <= 1'b0;
                        if (in_exponent == '1) begin
                            resultReg <= {in_sign, in_exponent, in_mantissa[MANT_WIDTH-1:0]};
                            validReg  <= 1'b1;
                            state     <= DONE;
                        end else if (!in_carry && captureMant == '0) begin
                            resultReg <= '0;
                            validReg  <= 1'b1;
                            state     <= DONE;
                        end else if (in_carry) begin
                            // Shift right to absorb the carry, folding the dropped bit into sticky.
                            workMant <= {1'b1, captureMant[WM-1:2], captureMant[1] | captureMant[0]};
                            workExp  <= {1'b0, in_exponent} + EXP_ONE;
                            state    <= NORM;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (workMant[WM-1]) begin
                        state <= ROUND;
                    end else if (workExp <= EXP_ONE) begin
                        resultReg    <= {workSign, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
                        underflowReg <= 1'b1;
                        validReg     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        workMant <= {workMant[WM-2:0], 1'b0};
                        workExp  <= workExp - EXP_ONE;
                    end
                end
                ROUND: begin
                    if (roundExp >= EXP_SAT) begin
                        resultReg   <= {workSign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                        overflowReg <= 1'b1;
                    end else begin
                        resultReg <= {workSign, roundExp[EXP_WIDTH-1:0], roundFrac};
                    end
                    workExp  <= roundExp;
                    validReg <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        validReg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign out_valid     = validReg;
    assign out_result    = resultReg;
    assign out_overflow  = overflowReg;
    assign out_underflow = underflowReg;

endmodule
